motor_pwm_driver: RTL and testbench

- Downstream stage of the line-follow steering block.
- Consumes its 4-bit direction code (motorIn) and 2-bit enable (motorEn), and drives two H-bridge channels (left, right) with PWM speed control.
- Provides soft-start ramping, and dead-time coasting on direction reversal, so the bridges never see an instantaneous forward/reverse swap.

---
 rtl/motor_pwm_driver.sv | 200 ++++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: two independent H-bridge channels driven from the
// line-follow steering block's direction/enable codes. Each channel has
// PWM speed control, a soft-start duty ramp and a dead-time coast before
// any direction reversal.
// Optional feature macro: SOFT_START_EN. When it is defined, the duty
// ramps up from 0. When it is undefined, drive starts directly at
// DUTY_MAX.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bridge off, pair 00, duty 0
// RAMP  | driving, duty climbs 1 count per RAMP_DIV clocks (SOFT_START_EN)
// RUN   | driving at DUTY_MAX, at_speed high
// DEAD  | coasting DEAD_CYC clocks before applying the reversed direction
// BRAKE | pair 11, enable held high (no PWM)
module motor_pwm_driver #(
  parameter int CNT_W    = 8,
  parameter int DUTY_MAX = 200,
  parameter int RAMP_DIV = 1024,
  parameter int DEAD_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] motor_in,
  input  logic [1:0] motor_en,
  output logic [3:0] hb_in,
  output logic [1:0] hb_en,
  output logic [1:0] at_speed,
  output logic [1:0] reversing
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
`ifdef SOFT_START_EN
  localparam logic [2:0] ST_RAMP  = 3'd1;
`endif
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DEAD  = 3'd3;
  localparam logic [2:0] ST_BRAKE = 3'd4;

  localparam logic [CNT_W-1:0] DUTY_RUN = CNT_W'(DUTY_MAX);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);
`ifdef SOFT_START_EN
  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam logic [PW-1:0] PRESC_LOAD = PW'(RAMP_DIV - 1);
`endif

  // Out-of-range parameters would silently break the ramp/dead timers.
  if (RAMP_DIV < 1 || DEAD_CYC < 1 || DUTY_MAX < 1 || DUTY_MAX > (2**CNT_W) - 1) begin : g_param_check
    $fatal(1, "motor_pwm_driver: illegal parameter value");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       in_q;
  logic [1:0]       en_q;

  // Shared free-running PWM counter; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + 1'b1;
  end

  // Single register stage on the command inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
      en_q <= '0;
    end else begin
      in_q <= motor_in;
      en_q <= motor_en;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [2:0]       state_q, state_d;
    logic [1:0]       pair_q, pair_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [1:0]       cmd;
    logic             en, is_dir, in_ramp, go_drive, pwm_on;

    assign cmd    = in_q[2*ch+1 -: 2];
    assign en     = en_q[ch];
    assign is_dir = cmd[1] ^ cmd[0];

`ifdef SOFT_START_EN
    logic [PW-1:0] presc_q, presc_d;
    assign in_ramp = (state_q == ST_RAMP);
`else
    assign in_ramp = 1'b0;
`endif

    // Next-state logic; priority is en=0 > brake > coast > direction compare.
    always_comb begin
      state_d  = state_q;
      pair_d   = pair_q;
      duty_d   = duty_q;
      dead_d   = dead_q;
      go_drive = 1'b0;
`ifdef SOFT_START_EN
      presc_d  = presc_q;
`endif
      if (state_q == ST_IDLE) begin
        if (en && is_dir) begin
          go_drive = 1'b1;
        end else if (en && cmd == 2'b11) begin
          state_d = ST_BRAKE;
          pair_d  = 2'b11;
        end
      end else if (!en || cmd == 2'b00) begin
        state_d = ST_IDLE;
        pair_d  = 2'b00;
        duty_d  = '0;
      end else if (cmd == 2'b11) begin
        state_d = ST_BRAKE;
        pair_d  = 2'b11;
        duty_d  = '0;
      end else if (state_q == ST_DEAD) begin
        // The newest commanded direction is what gets applied at expiry.
        if (dead_q == '0) go_drive = 1'b1;
        else              dead_d   = dead_q - 1'b1;
      end else if (state_q == ST_BRAKE) begin
        go_drive = 1'b1;
      end else if (state_q == ST_RUN || in_ramp) begin
        if (cmd != pair_q) begin
          state_d = ST_DEAD;
          pair_d  = 2'b00;
          duty_d  = '0;
          dead_d  = DEAD_LOAD;
        end
`ifdef SOFT_START_EN
        else if (in_ramp) begin
          if (presc_q == '0) begin
            presc_d = PRESC_LOAD;
            if (duty_q == DUTY_RUN - 1'b1) begin
              state_d = ST_RUN;
              duty_d  = DUTY_RUN;
            end else begin
              duty_d = duty_q + 1'b1;
            end
          end else begin
            presc_d = presc_q - 1'b1;
          end
        end
`endif
      end else begin
        state_d = ST_IDLE;
        pair_d  = 2'b00;
        duty_d  = '0;
      end

      if (go_drive) begin
        pair_d  = cmd;
`ifdef SOFT_START_EN
        state_d = ST_RAMP;
        duty_d  = '0;
        presc_d = PRESC_LOAD;
`else
        state_d = ST_RUN;
        duty_d  = DUTY_RUN;
`endif
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        pair_q  <= 2'b00;
        duty_q  <= '0;
        dead_q  <= '0;
`ifdef SOFT_START_EN
        presc_q <= '0;
`endif
      end else begin
        state_q <= state_d;
        pair_q  <= pair_d;
        duty_q  <= duty_d;
        dead_q  <= dead_d;
`ifdef SOFT_START_EN
        presc_q <= presc_d;
`endif
      end
    end

    // Bridge enable: PWM compare while driving, steady high while braking.
    always_comb begin
      pwm_on = 1'b0;
      if (in_ramp)                   pwm_on = (cnt_q < duty_q);
      else if (state_q == ST_RUN)    pwm_on = (cnt_q < DUTY_RUN);
      else if (state_q == ST_BRAKE)  pwm_on = 1'b1;
    end

    assign hb_in[2*ch+1 -: 2] = pair_q;
    assign hb_en[ch]          = pwm_on;
    assign at_speed[ch]       = (state_q == ST_RUN);
    assign reversing[ch]      = (state_q == ST_DEAD);
  end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed sequence followed by random
// commands, checked every cycle against a time-based behavioural model.
module tb_motor_pwm_driver;

  localparam int CNT_W    = 4;
  localparam int DUTY_MAX = 12;
  localparam int RAMP_DIV = 2;
  localparam int DEAD_CYC = 8;
`ifdef SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  // model modes
  localparam int OFF = 0, SPIN_UP = 1, CRUISE = 2, COAST_WAIT = 3, HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] motor_in = 4'b0000;
  logic [1:0] motor_en = 2'b00;
  logic [3:0] hb_in;
  logic [1:0] hb_en;
  logic [1:0] at_speed;
  logic [1:0] reversing;

  int total = 0;
  int bad   = 0;

  int         md   [2];
  int         dirv [2];
  int         rclk [2];
  int         dclk [2];
  int         m_cnt;
  logic [3:0] m_in;
  logic [1:0] m_en;
  logic [3:0] prev_in;

  motor_pwm_driver #(
    .CNT_W(CNT_W), .DUTY_MAX(DUTY_MAX), .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_in(motor_in), .motor_en(motor_en),
    .hb_in(hb_in), .hb_en(hb_en), .at_speed(at_speed), .reversing(reversing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      md[ch] = OFF; dirv[ch] = 0; rclk[ch] = 0; dclk[ch] = 0;
    end
    m_cnt = 0; m_in = 4'b0000; m_en = 2'b00; prev_in = 4'b0000;
  endtask

  task automatic start_drive(input int ch, input int c);
    dirv[ch] = c;
    rclk[ch] = 0;
    md[ch]   = SOFT ? SPIN_UP : CRUISE;
  endtask

  // One clock of the reference: decisions use the command registered at the previous edge.
  task automatic model_step();
    for (int ch = 0; ch < 2; ch++) begin
      int c;
      bit e;
      c = int'((m_in >> (2*ch)) & 4'd3);
      e = m_en[ch];
      if (md[ch] == OFF) begin
        if (e && (c == 1 || c == 2)) start_drive(ch, c);
        else if (e && c == 3)        md[ch] = HOLD;
      end else if (!e || c == 0) begin
        md[ch] = OFF;
      end else if (c == 3) begin
        md[ch] = HOLD;
      end else if (md[ch] == HOLD) begin
        start_drive(ch, c);
      end else if (md[ch] == COAST_WAIT) begin
        dclk[ch]++;
        if (dclk[ch] >= DEAD_CYC) start_drive(ch, c);
      end else if (c != dirv[ch]) begin
        md[ch] = COAST_WAIT; dclk[ch] = 0;
      end else if (md[ch] == SPIN_UP) begin
        rclk[ch]++;
        if (rclk[ch] / RAMP_DIV >= DUTY_MAX) md[ch] = CRUISE;
      end
    end
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_in  = motor_in;
    m_en  = motor_en;
  endtask

  task automatic check_outputs();
    logic [3:0] e_in;
    logic [1:0] e_en, e_spd, e_rev;
    logic       viol;
    int         pair;
    for (int ch = 0; ch < 2; ch++) begin
      pair = (md[ch] == SPIN_UP || md[ch] == CRUISE) ? dirv[ch] : (md[ch] == HOLD ? 3 : 0);
      e_in[2*ch +: 2] = 2'(pair);
      e_en[ch]  = (md[ch] == SPIN_UP) ? (m_cnt < rclk[ch] / RAMP_DIV) :
                  (md[ch] == CRUISE)  ? (m_cnt < DUTY_MAX) : (md[ch] == HOLD);
      e_spd[ch] = (md[ch] == CRUISE);
      e_rev[ch] = (md[ch] == COAST_WAIT);
    end
    chk("hb_in", hb_in, e_in);
    chk("hb_en", hb_en, e_en);
    chk("at_speed", at_speed, e_spd);
    chk("reversing", reversing, e_rev);
    viol = 1'b0;
    for (int ch = 0; ch < 2; ch++)
      if (hb_en[ch] && (prev_in[2*ch +: 2] ^ hb_in[2*ch +: 2]) == 2'b11 &&
          hb_in[2*ch] != hb_in[2*ch+1])
        viol = 1'b1;
    chk("no_hot_swap", viol, 1'b0);
    prev_in = hb_in;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    int n_on, n_rev, n_run;
    model_reset();

    // reset held with an active command
    rst_n = 1'b0; motor_in = 4'b1010; motor_en = 2'b11;
    repeat (3) tick();
    chk("rst_hb_in", hb_in, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk("rel_edge1_hb_in", hb_in, 4'b0000);
    tick();
    chk("rel_edge2_hb_in", hb_in, 4'b1010);

    // ramp to run
    repeat (22) tick();
    tick();
    chk("ramp_pre_speed", at_speed, SOFT ? 2'b00 : 2'b11);
    tick();
    chk("ramp_at_speed", at_speed, 2'b11);
    n_on = 0;
    repeat (16) begin tick(); n_on += int'(hb_en[1]); end
    chk("run_duty_left", n_on, 12);

    // left reversal, right untouched
    motor_in = 4'b0110;
    n_rev = 0; n_run = 0;
    repeat (16) begin
      tick();
      n_rev += int'(reversing[1]);
      n_run += int'(at_speed[0]);
    end
    chk("dead_len", n_rev, 8);
    chk("right_stays_run", n_run, 16);
    chk("rev_new_dir", hb_in[3:2], 2'b01);

    // brake during dead time, then drive with no dead time
    motor_in = 4'b1010;
    repeat (4) tick();
    chk("in_dead", reversing[1], 1'b1);
    motor_in = 4'b1110;
    repeat (2) tick();
    chk("brake_pair", hb_in[3:2], 2'b11);
    chk("brake_en", hb_en[1], 1'b1);
    repeat (5) tick();
    motor_in = 4'b1010;
    repeat (2) tick();
    chk("brake_to_drive_pair", hb_in[3:2], 2'b10);
    chk("brake_to_drive_nodead", reversing[1], 1'b0);

    // enable drop on left only
    repeat (30) tick();
    motor_en = 2'b01;
    repeat (2) tick();
    chk("endrop_pair", hb_in[3:2], 2'b00);
    chk("endrop_en", hb_en[1], 1'b0);
    n_on = 0;
    repeat (16) begin tick(); n_on += int'(hb_en[0]); end
    chk("run_duty_right", n_on, 12);

    // async reset while both channels are in dead time
    motor_en = 2'b11;
    repeat (30) tick();
    motor_in = 4'b0101;
    repeat (4) tick();
    chk("both_dead", reversing, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hb_in", hb_in, 4'b0000);
    chk("async_hb_en", hb_en, 2'b00);
    chk("async_at_speed", at_speed, 2'b00);
    chk("async_reversing", reversing, 2'b00);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;

    // random commands held for random spans
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) begin
        motor_in = 4'($urandom);
        motor_en = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
